// File: rtl/k005297_dlseq.sv
// Data-length transfer sequencer: a 20-phase one-hot frame rotor drives a clear/release/count
// handshake with a bit-serial length counter and reports completion, overflow and wrap errors.
module k005297_dlseq (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_CLK2M_PCEN_n,
    input  logic        i_START,
    input  logic [9:0]  i_TARGET_LEN,
    input  logic        i_ABORT,
    input  logic        i_UNIT_STB,
    input  logic        i_DLCNTR_LSB,
    input  logic        i_DLCNTR_CFLAG,
    output logic [19:0] o_ROT20_n,
    output logic        o_DLCNT_START_n,
    output logic        o_SUPBD_START_n,
    output logic        o_DLCNT_EN,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_ERR
);

    typedef enum logic [1:0] {IDLE, CLEAR, RELEASE, COUNT} state_t;

    state_t      state, state_nxt;
    logic [19:0] rot;
    logic [1:0]  pend, pend_nxt;
    logic        err, err_nxt;
    logic        frame_eq, frame_eq_nxt;
    logic [9:0]  target;
    logic        load_target;
    logic        done;
    logic        dl_en;
    logic        cen;
    logic        ph0, ph1, ph11, ph19;
    logic [9:0]  sel_ph;
    logic        sample_ph;
    logic        lsb_exp;

    assign cen  = !i_CLK2M_PCEN_n;
    assign ph0  = !rot[0];
    assign ph1  = !rot[1];
    assign ph11 = !rot[11];
    assign ph19 = !rot[19];

    // Phases 1..10 each select one target bit to compare against the serial counter bit.
    assign sel_ph    = ~rot[10:1];
    assign sample_ph = |sel_ph;
    assign lsb_exp   = |(sel_ph & target);

    always_comb begin
        state_nxt    = state;
        pend_nxt     = pend;
        err_nxt      = err;
        frame_eq_nxt = frame_eq;
        load_target  = 1'b0;
        done         = 1'b0;
        dl_en        = (state == COUNT) && ph1 && (pend != 2'd0);
        if (cen && !i_RST) begin
            if (ph0)
                frame_eq_nxt = 1'b1;
            else if (sample_ph && (i_DLCNTR_LSB != lsb_exp))
                frame_eq_nxt = 1'b0;
            if (state == IDLE) begin
                if (i_START && ph19) begin
                    state_nxt   = CLEAR;
                    load_target = 1'b1;
                    err_nxt     = 1'b0;
                end
            end else if (i_ABORT) begin
                state_nxt = IDLE;
                pend_nxt  = 2'd0;
            end else begin
                // A strobe coinciding with the phase-1 carry-in cancels out.
                if (state != CLEAR) begin
                    if (i_UNIT_STB && !dl_en) begin
                        if (pend == 2'd3) err_nxt = 1'b1;
                        else              pend_nxt = pend + 2'd1;
                    end else if (!i_UNIT_STB && dl_en) begin
                        pend_nxt = pend - 2'd1;
                    end
                end
                case (state)
                    CLEAR:   if (ph19) state_nxt = RELEASE;
                    RELEASE: state_nxt = COUNT;
                    COUNT: begin
                        if (ph11 && i_DLCNTR_CFLAG) err_nxt = 1'b1;
                        if (ph19 && frame_eq && (pend == 2'd0)) begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                            pend_nxt  = 2'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state    <= IDLE;
            rot      <= 20'hFFFFE;
            pend     <= 2'd0;
            err      <= 1'b0;
            frame_eq <= 1'b0;
            target   <= 10'd0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            err      <= err_nxt;
            frame_eq <= frame_eq_nxt;
            if (cen)         rot    <= {rot[18:0], rot[19]};
            if (load_target) target <= i_TARGET_LEN;
        end
    end

    assign o_ROT20_n       = rot;
    assign o_DLCNT_START_n = (state != CLEAR);
    assign o_SUPBD_START_n = (state != RELEASE);
    assign o_DLCNT_EN      = dl_en;
    assign o_BUSY          = (state != IDLE);
    assign o_DONE          = done;
    assign o_ERR           = err;

endmodule

// File: tb/tb_k005297_dlseq.sv
// Bench for k005297_dlseq: a transfer-timeline reference model plus an attached bit-serial
// length counter, compared against the DUT every cycle.
module tb_k005297_dlseq;

    logic        clk;
    logic        rst, en_n, start, abort, strobe, lsb, cflag;
    logic [9:0]  target;
    logic [19:0] rot_n;
    logic        clr_n, rel_n, dl_en, busy, done, err;

    k005297_dlseq dut (
        .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(en_n), .i_START(start),
        .i_TARGET_LEN(target), .i_ABORT(abort), .i_UNIT_STB(strobe),
        .i_DLCNTR_LSB(lsb), .i_DLCNTR_CFLAG(cflag), .o_ROT20_n(rot_n),
        .o_DLCNT_START_n(clr_n), .o_SUPBD_START_n(rel_n), .o_DLCNT_EN(dl_en),
        .o_BUSY(busy), .o_DONE(done), .o_ERR(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_done = 0, n_en = 0;
    bit chk_on = 1'b0;

    // Reference: m_t counts enabled cycles since the start was accepted (0 = idle);
    // 1..20 clearing, 21 releasing, 22+ counting. m_seen assembles the serial readout.
    int m_phase = 0, m_t = 0, m_pend = 0, m_tgt = 0, m_seen = 0;
    bit m_err = 1'b0;

    // Attached length counter: cleared while clear is asserted, adds the carry-in at phase 1.
    logic [9:0]  cnt = 10'd0;
    logic [10:0] rd  = 11'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int p;
        logic [10:0] sh;
        logic [19:0] rexp;
        bit en_e, done_e, clr_pre;
        #1;
        p = m_phase;
        if (p == 1) rd = {1'b0, cnt} + {10'd0, dl_en};
        sh    = rd >> (p - 1);
        lsb   = (p >= 1 && p <= 10) ? sh[0] : 1'($urandom);
        cflag = (p == 11) ? rd[10] : 1'($urandom);
        #1;
        en_e   = (m_t >= 22) && (p == 1) && (m_pend > 0);
        done_e = !en_n && !rst && !abort && (m_t >= 22) && (p == 19) && (m_seen == m_tgt) && (m_pend == 0);
        if (chk_on) begin
            rexp = ~(20'd1 << p);
            check("rot", 32'(rot_n), 32'(rexp));
            check("onehot", 32'($countones(~rot_n)), 32'd1);
            check("busy", 32'(busy), 32'(m_t != 0));
            check("clr_n", 32'(clr_n), 32'(!(m_t >= 1 && m_t <= 20)));
            check("rel_n", 32'(rel_n), 32'(m_t != 21));
            check("dlcnt_en", 32'(dl_en), 32'(en_e));
            check("done", 32'(done), 32'(done_e));
            check("err", 32'(err), 32'(m_err));
        end
        if (done) n_done++;
        if (dl_en && !en_n) n_en++;
        clr_pre = !clr_n;
        if (rst) begin
            m_phase = 0; m_t = 0; m_pend = 0; m_err = 1'b0; m_seen = 0;
        end else if (!en_n) begin
            if (p == 0) m_seen = 0;
            else if (p <= 10) m_seen = m_seen | (int'(lsb) << (p - 1));
            if (m_t == 0) begin
                if (start && p == 19) begin m_t = 1; m_tgt = int'(target); m_err = 1'b0; end
            end else if (abort) begin
                m_t = 0; m_pend = 0;
            end else begin
                if (m_t >= 21) begin
                    if (strobe && !en_e) begin
                        if (m_pend == 3) m_err = 1'b1; else m_pend++;
                    end else if (!strobe && en_e) m_pend--;
                end
                if (m_t >= 22 && p == 11 && cflag) m_err = 1'b1;
                if (done_e) begin m_t = 0; m_pend = 0; end
                else m_t++;
            end
            m_phase = (p + 1) % 20;
        end
        @(posedge clk);
        #1;
        if (!rst && !en_n) begin
            if (clr_pre) cnt = 10'd0;
            else if (p == 1) cnt = rd[9:0];
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en_n = 1'b0; start = 1'b0; abort = 1'b0; strobe = 1'b0; target = 10'd0;
    endtask

    task automatic begin_xfer(input int tg);
        target = 10'(tg);
        start  = 1'b1;
        for (int i = 0; i < 25 && m_t == 0; i++) step();
        start = 1'b0;
        check("start_accept", 32'(busy), 32'd1);
    endtask

    task automatic strobe_units(input int n, input int lo, input int hi);
        for (int u = 0; u < n; u++) begin
            repeat ($urandom_range(hi, lo)) step();
            strobe = 1'b1;
            step();
            strobe = 1'b0;
        end
    endtask

    task automatic finish_xfer(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy) break;
            start  = 1'($urandom);
            target = 10'($urandom);
            step();
        end
        start = 1'b0;
        check("xfer_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int en_cycles;
        rst = 1'b1; en_n = 1'b1; start = 1'b1; abort = 1'b1; strobe = 1'b1;
        target = 10'h3FF; lsb = 1'b0; cflag = 1'b0;
        step();
        chk_on = 1'b1;
        step();
        check("rst_rot", 32'(rot_n), 32'hFFFFE);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        idle_inputs();

        // Phase walk with occasional disabled cycles.
        en_cycles = 0;
        while (en_cycles < 40) begin
            en_n = ($urandom_range(2, 0) == 0);
            step();
            if (!en_n) en_cycles++;
        end
        en_n = 1'b0;
        check("walk_end", 32'(rot_n), 32'hFFFFE);

        // Target 3, three widely spaced units.
        n_done = 0; n_en = 0;
        begin_xfer(3);
        repeat (20) step();
        strobe_units(3, 21, 30);
        finish_xfer(200);
        check("t3_en_pulses", 32'(n_en), 32'd3);
        check("t3_done", 32'(n_done), 32'd1);
        check("t3_cnt", 32'(cnt), 32'd3);

        // Four strobes within one frame overflow the pending counter.
        n_en = 0;
        begin_xfer(5);
        repeat (22) step();
        strobe = 1'b1;
        repeat (4) step();
        strobe = 1'b0;
        check("ovf_err", 32'(err), 32'd1);
        repeat (60) step();
        check("ovf_pend3", 32'(n_en), 32'd3);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("err_sticky", 32'(err), 32'd1);

        // Target 0 completes in the first counting frame; new start clears the error.
        n_done = 0;
        begin_xfer(0);
        check("err_cleared", 32'(err), 32'd0);
        finish_xfer(60);
        check("t0_done", 32'(n_done), 32'd1);

        // Abort on the phase-19 cycle that would have completed.
        n_done = 0;
        begin_xfer(1);
        repeat (20) step();
        strobe_units(1, 3, 8);
        for (int i = 0; i < 60; i++) begin
            if (m_t >= 22 && m_phase == 19 && m_pend == 0 && m_seen == m_tgt) break;
            step();
        end
        abort = 1'b1; step(); abort = 1'b0;
        check("abort19_done", 32'(n_done), 32'd0);
        check("abort19_busy", 32'(busy), 32'd0);

        // Counter wraps 1023 -> 0 on one unit: carry flag at phase 11 raises the error.
        begin_xfer(7);
        repeat (20) step();
        cnt = 10'h3FF;
        strobe = 1'b1; step(); strobe = 1'b0;
        repeat (15) step();
        check("wrap_err", 32'(err), 32'd1);
        abort = 1'b1; step(); abort = 1'b0;

        // Randomized transfers with busy-time start noise.
        for (int it = 0; it < 5; it++) begin
            int tg;
            tg = $urandom_range(4, 0);
            n_done = 0;
            begin_xfer(tg);
            repeat (20) step();
            strobe_units(tg, 10, 30);
            finish_xfer(200);
            check("rand_done", 32'(n_done), 32'd1);
        end

        // Reset mid-transfer overrides enable, abort, start and strobe.
        begin_xfer(2);
        repeat (30) step();
        rst = 1'b1; en_n = 1'b1; strobe = 1'b1; abort = 1'b1; start = 1'b1;
        step();
        idle_inputs();
        check("midrst_rot", 32'(rot_n), 32'hFFFFE);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_clr", 32'(clr_n), 32'd1);
        repeat (5) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
